// File: rtl/ms_uart_pkg.sv
// Purpose : shared UART definitions: receiver FSM states, default frame constants, parity helper.
// Latency : n/a (types, constants and a combinational function only).
// Backpressure: n/a.
package ms_uart_pkg;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int DATA_BITS_DEF  = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } uart_state_t;

    // Even-parity bit for up to 32 data bits; callers zero-extend narrower
    // words, which does not change the XOR.
    function automatic logic even_parity(input logic [31:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/ms_uart_sync_fifo.sv
// Purpose : generic show-ahead synchronous FIFO; head entry is always visible on rd_dat.
// Latency : a write to an empty FIFO is visible on rd_vld/rd_dat one CLK after the write cycle.
// Backpressure: writes while full are discarded unless a read happens in the same cycle.
//
// Ports: CLK, RESETN (sync, active-low); wr_vld/wr_dat write side with full;
//        rd_vld/rd_rdy/rd_dat read side; count = exact occupancy 0..DEPTH.
module ms_uart_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       RESETN,
    input  logic                       wr_vld,
    input  logic [WIDTH-1:0]           wr_dat,
    output logic                       full,
    output logic                       rd_vld,
    input  logic                       rd_rdy,
    output logic [WIDTH-1:0]           rd_dat,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop;
    logic             push;

    assign rd_vld = (count != '0);
    assign full   = (count == DEPTH_C);
    assign pop    = rd_vld && rd_rdy;
    // When full, the slot being written is the head that is popped this cycle.
    assign push   = wr_vld && (!full || pop);
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ms_uart_rx_fifo.sv
// Purpose : oversampled UART receiver (8N1/8E1) with a show-ahead receive FIFO.
// Latency : entry visible on DVALID one CLK after the stop-bit sample TICK.
// Backpressure: DREADY pops the head; a frame completing while full is dropped and sets OVERRUN.
//
// Ports: CLK, RESETN (sync, active-low); TICK oversample enable; RXD async serial line;
//        DOUT/PERR/FERR/DVALID/DREADY receive port; OVERRUN sticky, CLR_ERR clears it;
//        BUSY frame in progress; COUNT FIFO occupancy.
module ms_uart_rx_fifo
    import ms_uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DATA_BITS  = DATA_BITS_DEF,
    parameter int PARITY_EN  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            CLK,
    input  logic                            RESETN,
    input  logic                            TICK,
    input  logic                            RXD,
    output logic [DATA_BITS-1:0]            DOUT,
    output logic                            PERR,
    output logic                            FERR,
    output logic                            DVALID,
    input  logic                            DREADY,
    output logic                            OVERRUN,
    input  logic                            CLR_ERR,
    output logic                            BUSY,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] COUNT
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    logic                 rx_meta;
    logic                 rx_s;
    uart_state_t          state;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr_r;
    logic                 busy_r;
    logic                 push;
    logic                 fifo_full;
    logic [DATA_BITS+1:0] push_dat;

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RXD;
            rx_s    <= rx_meta;
        end
    end

    // Push is combinational so the entry lands in the FIFO on the stop-sample edge.
    assign push     = (state == STOP) && TICK && (tick_cnt == FULL_M1);
    assign push_dat = {~rx_s, perr_r, shreg};

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state    <= IDLE;
            busy_r   <= 1'b0;
            tick_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            perr_r   <= 1'b0;
        end else if (TICK) begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state    <= START;
                        busy_r   <= 1'b1;
                        tick_cnt <= '0;
                    end
                end
                START: begin
                    if (tick_cnt == HALF_M1) begin
                        tick_cnt <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                            perr_r  <= 1'b0;
                        end else begin
                            // Start bit not low at its centre: treat as a glitch.
                            state  <= IDLE;
                            busy_r <= 1'b0;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_cnt == FULL_M1) begin
                        tick_cnt       <= '0;
                        shreg[bit_idx] <= rx_s;
                        bit_idx        <= bit_idx + 1'b1;
                        if (bit_idx == LAST_BIT)
                            state <= (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (tick_cnt == FULL_M1) begin
                        tick_cnt <= '0;
                        perr_r   <= rx_s ^ even_parity(32'(shreg));
                        state    <= STOP;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (tick_cnt == FULL_M1) begin
                        tick_cnt <= '0;
                        if (rx_s) begin
                            state  <= IDLE;
                            busy_r <= 1'b0;
                        end else begin
                            state <= BREAK;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                BREAK: begin
                    // Wait out a held-low line so it reports only one framing error.
                    if (rx_s) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN)
            OVERRUN <= 1'b0;
        else if (push && fifo_full && !(DVALID && DREADY))
            OVERRUN <= 1'b1;
        else if (CLR_ERR)
            OVERRUN <= 1'b0;
    end

    assign BUSY = busy_r;

    ms_uart_sync_fifo #(
        .WIDTH (DATA_BITS + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK    (CLK),
        .RESETN (RESETN),
        .wr_vld (push),
        .wr_dat (push_dat),
        .full   (fifo_full),
        .rd_vld (DVALID),
        .rd_rdy (DREADY),
        .rd_dat ({FERR, PERR, DOUT}),
        .count  (COUNT)
    );

endmodule

// File: doc/ms_uart_rx_fifo.md
Name: ms_uart_rx_fifo

Overview:
- Fully synchronous UART receiver. It deserialises 8N1 / 8E1 frames from the line driven by the team's UART transmitter.
- Line timing is recovered from an oversampled tick enable; the block samples at bit centre.
- Each received byte and its error flags are buffered in a small show-ahead FIFO drained over a valid/ready handshake.
- Sits between the pad/loopback RX line and the user-side data port, alongside the existing baud generator.

Parameters:
- OVERSAMPLE, 16, TICK pulses per bit period; must be even and ≥ 4.
- DATA_BITS, 8, data bits per frame, LSB first.
- PARITY_EN, 1, 1 = one even-parity bit after the data bits; 0 = no parity bit.
- FIFO_DEPTH, 4, number of receive entries; power of two.

Ports:
- CLK  in  1  system clock.
- RESETN  in  1  reset: RESETN, synchronous, active-low; clock CLK.
- TICK  in  1  one-CLK-wide enable at baud×OVERSAMPLE, synchronous to CLK.
- RXD  in  1  serial line, asynchronous, idle high.
- DOUT  out  DATA_BITS  data of FIFO head entry.
- PERR  out  1  parity-error flag of head entry.
- FERR  out  1  framing-error flag of head entry.
- DVALID  out  1  FIFO not empty.
- DREADY  in  1  consumer accepts head entry when DVALID&&DREADY.
- OVERRUN  out  1  sticky; a completed frame was dropped because the FIFO was full.
- CLR_ERR  in  1  clears OVERRUN.
- BUSY  out  1  FSM not in IDLE.
- COUNT  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy.

Behaviour:
- RXD passes through a 2-flop synchroniser (rx_s), reset value 1. All FSM activity advances only on cycles with TICK=1.
- Reset values: DOUT=0, PERR=0, FERR=0, DVALID=0, OVERRUN=0, BUSY=0, COUNT=0. FSM goes to IDLE, FIFO is emptied, tick and bit counters are cleared.
- Reset mid-frame aborts the frame. Nothing is pushed for it.
- IDLE: on a TICK with rx_s=0, go to START with tick_cnt=0.
- START: increment tick_cnt each TICK. At tick_cnt==OVERSAMPLE/2-1, sample rx_s.
  - rx_s=0: go to DATA with tick_cnt=0, bit_idx=0.
  - rx_s=1: glitch; return to IDLE, no push.
- DATA: at tick_cnt==OVERSAMPLE-1, shift rx_s into shreg[bit_idx] (LSB first), clear tick_cnt, increment bit_idx. After bit DATA_BITS-1, go to PARITY if PARITY_EN, else STOP.
- PARITY: sample at tick_cnt==OVERSAMPLE-1. perr = sample XOR (XOR-reduce of data). Even parity: the sampled bit equals the XOR of the data bits.
- STOP: sample at tick_cnt==OVERSAMPLE-1 (stop-bit centre). ferr = (sample==0). Push {ferr, perr, data} in the same cycle.
  - ferr=0: go to IDLE, so a back-to-back start bit is detected on the next TICK.
  - ferr=1: go to BREAK.
- BREAK: wait for a TICK with rx_s=1, then go to IDLE. A held-low line therefore yields exactly one FERR frame.
- Push when full and no pop in that cycle: entry dropped, OVERRUN←1. It stays set until CLR_ERR=1 or reset. If CLR_ERR and a new overrun coincide, set wins.
- FIFO is show-ahead: DOUT/PERR/FERR are registered from the head entry. With PARITY_EN=0, PERR is always 0.
  - Push to empty FIFO: DVALID rises on the CLK edge after the push cycle (1-cycle latency from the stop-sample TICK).
  - Pop on DVALID&&DREADY: the next entry appears the following cycle, or DVALID falls if none remains.
  - Simultaneous push and pop when full: both occur, no overrun, COUNT unchanged.
  - Simultaneous push and pop when COUNT=1: the new entry becomes head and DVALID stays 1.
  - DREADY while DVALID=0: ignored.
- Pointers wrap modulo FIFO_DEPTH. COUNT is the exact occupancy, 0..FIFO_DEPTH.
- BUSY=1 in START, DATA, PARITY, STOP and BREAK.

Decomposition:
- Shared package ms_uart_pkg holds:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP, BREAK).
  - Default OVERSAMPLE / DATA_BITS constants.
  - An even-parity function, reused later by a rewritten transmitter.
- One natural sub-module: ms_uart_sync_fifo (parameterised width/depth, show-ahead, push/pop/full/empty/count). The FSM and synchroniser stay in the top module.

Test Plan:
- 8E1 frame 0xA5 (parity bit 0) at 16 ticks/bit, DREADY=1 → one DVALID pulse, DOUT=0xA5, PERR=0, FERR=0, BUSY low after the stop sample.
- Frame 0x3C with parity bit forced to 1 → DOUT=0x3C, PERR=1, FERR=0.
- Frame 0x81 with stop bit 0, line then held low for 40 bit times → exactly one entry with FERR=1. No further frames until the line goes high; a following 0x55 is received clean.
- RXD low pulse of 5 ticks, then high → FSM returns to IDLE, COUNT stays 0, no push.
- Five back-to-back frames 0x01..0x05 with DREADY=0:
  - COUNT=4, OVERRUN=1.
  - Popping yields 0x01, 0x02, 0x03, 0x04 in order.
  - CLR_ERR clears OVERRUN.
- RESETN=0 for one cycle during the DATA state of frame 0xF0 → all outputs return to reset values. A subsequent 0x0F frame is received with no error flags.
